// File: rtl/mem_stage.sv
// MEM pipeline stage: word loads/stores over a req/ack data-memory port,
// stalls upstream while an access is in flight, and registers MEM/WB outputs.
module mem_stage #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        clk_i,
  input  logic        start_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic        RegWrite_i,
  input  logic        MemToReg_i,
  input  logic [31:0] ALUResult_i,
  input  logic [31:0] VALUResult_i,
  input  logic [31:0] RDData_i,
  input  logic [4:0]  RDaddr_i,
  input  logic [31:0] instr_i,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        stall_o,
  output logic        err_o,
  output logic        RegWrite_o,
  output logic        MemToReg_o,
  output logic [4:0]  RDaddr_o,
  output logic [31:0] ALUResult_o,
  output logic [31:0] VALUResult_o,
  output logic [31:0] MemData_o,
  output logic [31:0] instr_o
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [31:0]      ldata_reg;
  logic             timeout_reg;
  logic             mem;
  logic             misaligned;

  assign mem        = MemRead_i | MemWrite_i;
  assign misaligned = (ALUResult_i[1:0] != 2'b00);

  // Gated by reset so the stall line is low while the stage is held in reset.
  always_comb begin
    stall_o = start_i & (((state_reg == IDLE) & mem & ~misaligned) |
                         (state_reg == ACCESS));
  end

  always_ff @(posedge clk_i or negedge start_i) begin
    if (!start_i) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      ldata_reg    <= '0;
      timeout_reg  <= 1'b0;
      mem_req_o    <= 1'b0;
      mem_we_o     <= 1'b0;
      mem_addr_o   <= '0;
      mem_wdata_o  <= '0;
      err_o        <= 1'b0;
      RegWrite_o   <= 1'b0;
      MemToReg_o   <= 1'b0;
      RDaddr_o     <= '0;
      ALUResult_o  <= '0;
      VALUResult_o <= '0;
      MemData_o    <= '0;
      instr_o      <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (mem && !misaligned) begin
            mem_req_o   <= 1'b1;
            mem_we_o    <= MemWrite_i;
            mem_addr_o  <= ALUResult_i;
            mem_wdata_o <= RDData_i;
            cnt_reg     <= '0;
            state_reg   <= ACCESS;
            RegWrite_o  <= 1'b0;
            MemToReg_o  <= 1'b0;
            instr_o     <= '0;
          end else begin
            // Plain ALU op, or a misaligned access retired as a bubble.
            if (mem) begin
              err_o <= 1'b1;
            end
            RegWrite_o   <= RegWrite_i & ~mem;
            MemToReg_o   <= MemToReg_i & ~mem;
            RDaddr_o     <= RDaddr_i;
            ALUResult_o  <= ALUResult_i;
            VALUResult_o <= VALUResult_i;
            MemData_o    <= '0;
            instr_o      <= instr_i;
          end
        end

        ACCESS: begin
          RegWrite_o <= 1'b0;
          MemToReg_o <= 1'b0;
          instr_o    <= '0;
          if (mem_ack_i) begin
            ldata_reg   <= mem_we_o ? 32'h0 : mem_rdata_i;
            timeout_reg <= 1'b0;
            mem_req_o   <= 1'b0;
            state_reg   <= DONE;
          end else if (cnt_reg == TERM_CNT) begin
            ldata_reg   <= '0;
            timeout_reg <= 1'b1;
            err_o       <= 1'b1;
            mem_req_o   <= 1'b0;
            state_reg   <= DONE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end

        DONE: begin
          RegWrite_o   <= RegWrite_i & ~timeout_reg;
          MemToReg_o   <= MemToReg_i;
          RDaddr_o     <= RDaddr_i;
          ALUResult_o  <= ALUResult_i;
          VALUResult_o <= VALUResult_i;
          MemData_o    <= ldata_reg;
          instr_o      <= instr_i;
          state_reg    <= IDLE;
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized loads,
// stores and ALU ops checked against a transaction-level expectation model.
module tb_mem_stage;

  localparam int TO = 16;

  logic        clk_i = 1'b0;
  logic        start_i;
  logic        MemRead_i, MemWrite_i, RegWrite_i, MemToReg_i;
  logic [31:0] ALUResult_i, VALUResult_i, RDData_i, instr_i;
  logic [4:0]  RDaddr_i;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        mem_req_o, mem_we_o, stall_o, err_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        RegWrite_o, MemToReg_o;
  logic [4:0]  RDaddr_o;
  logic [31:0] ALUResult_o, VALUResult_o, MemData_o, instr_o;

  int vectors = 0;
  int miscompares = 0;

  // Expectation state: sticky error and last retired WB values (for hold checks).
  logic        err_exp;
  logic [31:0] prev_alu, prev_valu;

  mem_stage #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
    .clk_i(clk_i), .start_i(start_i),
    .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
    .RegWrite_i(RegWrite_i), .MemToReg_i(MemToReg_i),
    .ALUResult_i(ALUResult_i), .VALUResult_i(VALUResult_i),
    .RDData_i(RDData_i), .RDaddr_i(RDaddr_i), .instr_i(instr_i),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .stall_o(stall_o), .err_o(err_o),
    .RegWrite_o(RegWrite_o), .MemToReg_o(MemToReg_o),
    .RDaddr_o(RDaddr_o), .ALUResult_o(ALUResult_o),
    .VALUResult_o(VALUResult_o), .MemData_o(MemData_o), .instr_o(instr_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    MemRead_i = 0; MemWrite_i = 0; RegWrite_i = 0; MemToReg_i = 0;
    ALUResult_i = 0; VALUResult_i = 0; RDData_i = 0; RDaddr_i = 0;
    instr_i = 0; mem_ack_i = 0; mem_rdata_i = 0;
  endtask

  // Issue one instruction, act as the memory (ack on access cycle ack_at,
  // 0 or >TO meaning never), and check the whole transaction.
  task automatic do_instr(input string name, input logic rd, input logic wr,
                          input logic rw, input logic m2r,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] valu, input logic [31:0] instr,
                          input logic [4:0] rda, input int ack_at,
                          input logic [31:0] rdata);
    logic mem, mis, amem, tout, exp_rw, exp_m2r;
    logic [31:0] exp_md;
    int exp_stall, stalls, acc;
    mem  = rd | wr;
    mis  = mem && (addr[1:0] != 2'b00);
    amem = mem && !mis;
    tout = amem && (ack_at < 1 || ack_at > TO);
    exp_stall = amem ? 1 + (tout ? TO : ack_at) : 0;
    exp_rw  = rw && !mis && !tout;
    exp_m2r = m2r && !mis;
    exp_md  = (amem && !wr && !tout) ? rdata : 32'h0;

    @(negedge clk_i);
    MemRead_i = rd; MemWrite_i = wr; RegWrite_i = rw; MemToReg_i = m2r;
    ALUResult_i = addr; RDData_i = wdata; VALUResult_i = valu;
    instr_i = instr; RDaddr_i = rda; mem_ack_i = 0;
    #1;
    stalls = 0; acc = 0;
    while (stall_o === 1'b1 && stalls < 64) begin
      stalls++;
      if (mem_req_o === 1'b1) begin
        acc++;
        vectors++;
        if (mem_addr_o !== addr || mem_we_o !== wr || (wr && mem_wdata_o !== wdata)) begin
          miscompares++;
          $display("FAIL %s req_fields: addr=%h we=%b wdata=%h, required addr=%h we=%b wdata=%h",
                   name, mem_addr_o, mem_we_o, mem_wdata_o, addr, wr, wdata);
        end
        mem_ack_i   = (acc == ack_at);
        mem_rdata_i = mem_ack_i ? rdata : $urandom();
      end
      @(posedge clk_i); #1;
      mem_ack_i = 0;
      vectors++;
      if (RegWrite_o !== 1'b0 || MemToReg_o !== 1'b0 || instr_o !== 32'h0 ||
          ALUResult_o !== prev_alu || VALUResult_o !== prev_valu) begin
        miscompares++;
        $display("FAIL %s bubble: rw=%b m2r=%b instr=%h alu=%h valu=%h, required 0 0 0 %h %h",
                 name, RegWrite_o, MemToReg_o, instr_o, ALUResult_o, VALUResult_o,
                 prev_alu, prev_valu);
      end
      @(negedge clk_i); #1;
    end

    vectors++;
    if (stalls != exp_stall) begin
      miscompares++;
      $display("FAIL %s stall_cycles: got %0d, required %0d", name, stalls, exp_stall);
    end
    vectors++;
    if (mem_req_o !== 1'b0) begin
      miscompares++;
      $display("FAIL %s req_after: mem_req_o=%b, required 0", name, mem_req_o);
    end

    @(posedge clk_i); #1;
    err_exp = err_exp | mis | tout;
    vectors++;
    if (RegWrite_o !== exp_rw || MemToReg_o !== exp_m2r || MemData_o !== exp_md ||
        ALUResult_o !== addr || VALUResult_o !== valu || RDaddr_o !== rda ||
        instr_o !== instr) begin
      miscompares++;
      $display("FAIL %s retire: rw=%b m2r=%b md=%h alu=%h valu=%h rd=%0d instr=%h, required %b %b %h %h %h %0d %h",
               name, RegWrite_o, MemToReg_o, MemData_o, ALUResult_o, VALUResult_o,
               RDaddr_o, instr_o, exp_rw, exp_m2r, exp_md, addr, valu, rda, instr);
    end
    vectors++;
    if (err_o !== err_exp || mem_req_o !== 1'b0) begin
      miscompares++;
      $display("FAIL %s err_req: err=%b req=%b, required err=%b req=0",
               name, err_o, mem_req_o, err_exp);
    end
    prev_alu  = addr;
    prev_valu = valu;
    $display("txn %s rd=%b wr=%b addr=%h ack_at=%0d stalls=%0d md=%h err=%b",
             name, rd, wr, addr, ack_at, stalls, MemData_o, err_o);
  endtask

  task automatic test_reset();
    start_i = 0;
    clear_inputs();
    MemRead_i = 1; ALUResult_i = 32'h100;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i); #1;
    vectors++;
    if ({mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, stall_o, err_o, RegWrite_o,
         MemToReg_o, RDaddr_o, ALUResult_o, VALUResult_o, MemData_o, instr_o} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: req=%b stall=%b err=%b alu=%h, required all 0",
               mem_req_o, stall_o, err_o, ALUResult_o);
    end
    clear_inputs();
    @(negedge clk_i);
    start_i = 1;
    err_exp = 0; prev_alu = 0; prev_valu = 0;
  endtask

  task automatic test_alu();
    do_instr("alu", 0, 0, 1, 0, 32'h1234, 32'h0, 32'h5555AAAA, 32'h00A50533, 5'd10, 0, 32'h0);
  endtask

  task automatic test_load();
    do_instr("load_ack3", 1, 0, 1, 1, 32'h100, 32'h0, 32'h1, 32'h00042503, 5'd10, 3, 32'hDEADBEEF);
  endtask

  task automatic test_store();
    do_instr("store_ack1", 0, 1, 0, 0, 32'h20, 32'hCAFEF00D, 32'h2, 32'h00A42023, 5'd0, 1, 32'h12345678);
  endtask

  task automatic test_timeout();
    do_instr("load_timeout", 1, 0, 1, 1, 32'h40, 32'h0, 32'h3, 32'h04002503, 5'd11, 0, 32'h0);
  endtask

  task automatic test_ack_terminal();
    do_instr("load_ack16", 1, 0, 1, 1, 32'h40, 32'h0, 32'h4, 32'h04002583, 5'd12, TO, 32'hA5A5C3C3);
  endtask

  task automatic test_misaligned();
    do_instr("load_misaligned", 1, 0, 1, 1, 32'h41, 32'h0, 32'h5, 32'h04102503, 5'd13, 1, 32'hFFFFFFFF);
  endtask

  task automatic test_reset_mid_access();
    @(negedge clk_i);
    clear_inputs();
    MemRead_i = 1; RegWrite_i = 1; ALUResult_i = 32'h80; instr_i = 32'h08002503; RDaddr_i = 5'd9;
    @(posedge clk_i); #1;
    vectors++;
    if (mem_req_o !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_mid req_issued: mem_req_o=%b, required 1", mem_req_o);
    end
    @(negedge clk_i); #1;
    start_i = 0;
    #1;
    vectors++;
    if (mem_req_o !== 1'b0 || stall_o !== 1'b0 || err_o !== 1'b0 || RegWrite_o !== 1'b0 ||
        mem_addr_o !== 32'h0 || ALUResult_o !== 32'h0 || MemData_o !== 32'h0) begin
      miscompares++;
      $display("FAIL rst_mid async_clear: req=%b stall=%b err=%b rw=%b addr=%h alu=%h md=%h, required all 0",
               mem_req_o, stall_o, err_o, RegWrite_o, mem_addr_o, ALUResult_o, MemData_o);
    end
    clear_inputs();
    @(negedge clk_i);
    start_i = 1;
    mem_ack_i = 1; mem_rdata_i = 32'hBAD0BAD0;
    @(posedge clk_i); #1;
    mem_ack_i = 0;
    vectors++;
    if (mem_req_o !== 1'b0 || err_o !== 1'b0 || MemData_o !== 32'h0 || stall_o !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid late_ack: req=%b err=%b md=%h stall=%b, required 0 0 0 0",
               mem_req_o, err_o, MemData_o, stall_o);
    end
    err_exp = 0; prev_alu = 0; prev_valu = 0;
    do_instr("load_after_rst", 1, 0, 1, 1, 32'h84, 32'h0, 32'h6, 32'h08402503, 5'd9, 2, 32'h0BADF00D);
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      int kind;
      logic rd, wr;
      kind = $urandom_range(0, 3);
      rd = (kind == 1) || (kind == 3);
      wr = (kind >= 2);
      do_instr("random", rd, wr, 1'($urandom()), 1'($urandom()),
               $urandom() & 32'hFFFF_FFFC, $urandom(), $urandom(), $urandom(),
               5'($urandom()), $urandom_range(1, TO), $urandom());
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_timeout();
    test_reset_mid_access();
    test_ack_terminal();
    test_random();
    test_misaligned();
    @(negedge clk_i);
    clear_inputs();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
